imba_cursor_overlay: RTL

IMBA_CURSOR_OVERLAY -- requirements
Module: imba_cursor_overlay

---
 rtl/imba_overlay_pkg.sv | 51 +++++
 rtl/imba_btn_repeat.sv | 49 ++++
 rtl/imba_cursor_overlay.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/imba_overlay_pkg.sv
// Shared geometry, FSM state type and coordinate-step helper for the cursor overlay.
// IMBA_CURSOR_WRAP_EN selects wrap-around cursor moves instead of edge clamping.
package imba_overlay_pkg;

    localparam int SCR_W    = 1280;
    localparam int SCR_H    = 1024;
    localparam int MENU_W   = 160;
    localparam int MENU_H   = 128;
    localparam int ROW_H    = 32;
    localparam int ROW_SH   = $clog2(ROW_H);
    localparam int BORDER_W = 2;
    localparam int CUR_ARM  = 6;
    localparam int RST_X    = 640;
    localparam int RST_Y    = 512;
    localparam int AX_MAX   = SCR_W - MENU_W;
    localparam int AY_MAX   = SCR_H - MENU_H;

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPEN    = 2'd1,
        ST_CONFIRM = 2'd2
    } menu_state_t;

    function automatic logic signed [12:0] abs13(input logic signed [12:0] a);
        return (a < 13'sd0) ? -a : a;
    endfunction

    // Signed 13-bit so a decrement at 0 goes negative instead of wrapping to 8191.
    function automatic logic [11:0] move_coord(input logic [11:0] cur, input logic inc,
                                               input logic dec, input int step, input int lim);
        logic signed [12:0] n;
        n = $signed({1'b0, cur});
        if (inc)
            n = n + 13'(step);
        else if (dec)
            n = n - 13'(step);
`ifdef IMBA_CURSOR_WRAP_EN
        if (n >= 13'(lim))
            n = n - 13'(lim);
        else if (n < 13'sd0)
            n = n + 13'(lim);
`else
        if (n >= 13'(lim))
            n = 13'(lim - 1);
        else if (n < 13'sd0)
            n = 13'sd0;
`endif
        return n[11:0];
    endfunction

endpackage

// File: rtl/imba_btn_repeat.sv
// Button synchroniser + rising-edge step with hold-delay auto-repeat.
// Step is combinational from the synchronised level, 2 cycles after the raw edge.
module imba_btn_repeat #(
    parameter int HOLD_DLY   = 12_000_000,
    parameter int REPEAT_PER = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_step
);
    localparam int CW = $clog2(((HOLD_DLY > REPEAT_PER) ? HOLD_DLY : REPEAT_PER) + 1);

    logic [1:0]    r_sync;
    logic          r_prev;
    logic          r_rep;
    logic [CW-1:0] r_cnt;
    logic          w_lvl;
    logic          w_rise;
    logic          w_due;

    assign w_lvl  = r_sync[1];
    assign w_rise = w_lvl & ~r_prev;
    // r_cnt counts cycles since the last step; the first gap is HOLD_DLY, later ones REPEAT_PER
    assign w_due  = r_rep ? (r_cnt == CW'(REPEAT_PER)) : (r_cnt == CW'(HOLD_DLY));
    assign o_step = w_lvl & (w_rise | w_due);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rep  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_prev <= w_lvl;
            if (!w_lvl) begin
                r_cnt <= '0;
                r_rep <= 1'b0;
            end else if (o_step) begin
                r_cnt <= CW'(1);
                r_rep <= ~w_rise;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/imba_cursor_overlay.sv
// Cursor cross + pop-up 4-row menu overlay; all Condition outputs are registered 1 cycle after the coordinates.
// Build with IMBA_CURSOR_WRAP_EN for wrap-around cursor moves (default clamps at the screen edge).
module imba_cursor_overlay
    import imba_overlay_pkg::*;
#(
    parameter int STEP       = 4,
    parameter int HOLD_DLY   = 12_000_000,
    parameter int REPEAT_PER = 2_000_000
) (
    input  logic        CLK_VGA,
    input  logic        RESET_N,
    input  logic [11:0] VGA_HORZ_COORD,
    input  logic [11:0] VGA_VERT_COORD,
    input  logic        BTN_U,
    input  logic        BTN_D,
    input  logic        BTN_L,
    input  logic        BTN_R,
    input  logic        BTN_C,
    output logic        Condition_For_Cursor,
    output logic        Condition_For_Cursor_Menu,
    output logic        Condition_For_Cursor_Border,
    output logic        Condition_For_Cursor_Text,
    output logic [11:0] Cursor_X,
    output logic [11:0] Cursor_Y,
    output logic [1:0]  Menu_Sel,
    output logic        Select_Pulse
);
    logic [4:0]  w_btn;
    logic [4:0]  w_step;
    logic        w_go_u, w_go_d, w_go_l, w_go_r, w_go_c;

    menu_state_t r_state;
    logic [1:0]  r_sel;
    logic        r_pulse;
    logic [11:0] r_px, r_py, r_cur_x, r_cur_y, r_ax, r_ay;
    logic        r_on_cur, r_menu, r_border, r_text;

    logic signed [12:0] w_h, w_v, w_dh, w_dv, w_mh, w_mv;
    logic        w_on_cur, w_in_box, w_edge, w_row, w_show;

    assign w_btn = {BTN_C, BTN_R, BTN_L, BTN_D, BTN_U};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        imba_btn_repeat #(
            .HOLD_DLY   (HOLD_DLY),
            .REPEAT_PER (REPEAT_PER)
        ) u_btn (
            .clk    (CLK_VGA),
            .rst_n  (RESET_N),
            .i_btn  (w_btn[g]),
            .o_step (w_step[g])
        );
    end

    // Opposing steps cancel; C overrides any move in the same cycle
    assign w_go_c = w_step[4];
    assign w_go_u = w_step[0] & ~w_step[1] & ~w_go_c;
    assign w_go_d = w_step[1] & ~w_step[0] & ~w_go_c;
    assign w_go_l = w_step[2] & ~w_step[3] & ~w_go_c;
    assign w_go_r = w_step[3] & ~w_step[2] & ~w_go_c;

    always_ff @(posedge CLK_VGA or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_CLOSED;
            r_sel   <= 2'd0;
            r_pulse <= 1'b0;
            r_px    <= 12'(RST_X);
            r_py    <= 12'(RST_Y);
            r_cur_x <= 12'(RST_X);
            r_cur_y <= 12'(RST_Y);
            r_ax    <= '0;
            r_ay    <= '0;
        end else begin
            r_pulse <= 1'b0;
            // Displayed position only changes at frame origin to avoid a torn cursor
            if (VGA_HORZ_COORD == 12'd0 && VGA_VERT_COORD == 12'd0) begin
                r_cur_x <= r_px;
                r_cur_y <= r_py;
            end
            case (r_state)
                ST_CLOSED: begin
                    if (w_go_c) begin
                        r_state <= ST_OPEN;
                        r_sel   <= 2'd0;
                        r_ax    <= (r_cur_x > 12'(AX_MAX)) ? 12'(AX_MAX) : r_cur_x;
                        r_ay    <= (r_cur_y > 12'(AY_MAX)) ? 12'(AY_MAX) : r_cur_y;
                    end else begin
                        r_px <= move_coord(r_px, w_go_r, w_go_l, STEP, SCR_W);
                        r_py <= move_coord(r_py, w_go_d, w_go_u, STEP, SCR_H);
                    end
                end
                ST_OPEN: begin
                    if (w_go_c) begin
                        r_state <= ST_CONFIRM;
                        r_pulse <= 1'b1;
                    end else if (w_go_u) begin
                        r_sel <= r_sel - 2'd1;
                    end else if (w_go_d) begin
                        r_sel <= r_sel + 2'd1;
                    end
                end
                default: r_state <= ST_CLOSED;
            endcase
        end
    end

    assign w_h  = $signed({1'b0, VGA_HORZ_COORD});
    assign w_v  = $signed({1'b0, VGA_VERT_COORD});
    assign w_dh = w_h - $signed({1'b0, r_cur_x});
    assign w_dv = w_v - $signed({1'b0, r_cur_y});
    assign w_mh = w_h - $signed({1'b0, r_ax});
    assign w_mv = w_v - $signed({1'b0, r_ay});

    assign w_on_cur = ((w_dh == 13'sd0) && (abs13(w_dv) <= 13'(CUR_ARM))) ||
                      ((w_dv == 13'sd0) && (abs13(w_dh) <= 13'(CUR_ARM)));
    assign w_in_box = (w_mh >= 13'sd0) && (w_mh < 13'(MENU_W)) &&
                      (w_mv >= 13'sd0) && (w_mv < 13'(MENU_H));
    assign w_edge   = (w_mh < 13'(BORDER_W)) || (w_mh >= 13'(MENU_W - BORDER_W)) ||
                      (w_mv < 13'(BORDER_W)) || (w_mv >= 13'(MENU_H - BORDER_W));
    assign w_row    = (w_mv[ROW_SH +: 2] == r_sel);
    assign w_show   = w_in_box && (r_state == ST_OPEN);

    always_ff @(posedge CLK_VGA or negedge RESET_N) begin
        if (!RESET_N) begin
            r_on_cur <= 1'b0;
            r_menu   <= 1'b0;
            r_border <= 1'b0;
            r_text   <= 1'b0;
        end else begin
            r_on_cur <= w_on_cur;
            r_menu   <= w_show;
            r_border <= w_show & w_edge;
            r_text   <= w_show & ~w_edge & w_row;
        end
    end

    assign Condition_For_Cursor        = r_on_cur;
    assign Condition_For_Cursor_Menu   = r_menu;
    assign Condition_For_Cursor_Border = r_border;
    assign Condition_For_Cursor_Text   = r_text;
    assign Cursor_X                    = r_cur_x;
    assign Cursor_Y                    = r_cur_y;
    assign Menu_Sel                    = r_sel;
    assign Select_Pulse                = r_pulse;

endmodule
